// File: rtl/mitchell_log2_pipe.sv
// Three-stage Mitchell log2 approximation: leading-one detect, then linear fraction.
// Output is {k, frac} in unsigned Q(INT_WIDTH.FRAC_WIDTH) with a valid/ready handshake.
module mitchell_log2_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int INT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] log_out,
  output logic                          zero_flag,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int EXT_WIDTH = DATA_WIDTH + FRAC_WIDTH;

  // Priority encoder: index of the highest set bit, 0 for an all-zero sample.
  function automatic logic [INT_WIDTH-1:0] msb_index(input logic [DATA_WIDTH-1:0] x);
    logic [INT_WIDTH-1:0] k;
    k = {INT_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (x[i]) begin
        k = INT_WIDTH'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

  // frac = (x - 2^k) * 2^F / 2^k, truncated; covers both shift directions in one path.
  function automatic logic [FRAC_WIDTH-1:0] calc_frac(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [INT_WIDTH-1:0]  k);
    logic [EXT_WIDTH-1:0] m_ext;
    m_ext = {{FRAC_WIDTH{1'b0}}, x} & ~({{(EXT_WIDTH-1){1'b0}}, 1'b1} << k);
    m_ext = (m_ext << FRAC_WIDTH) >> k;
    return m_ext[FRAC_WIDTH-1:0];
  endfunction

  logic                  stall_s;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s2_valid_r;
  logic [DATA_WIDTH-1:0] s2_data_r;
  logic [INT_WIDTH-1:0]  s2_k_r;
  logic                  s2_zero_r;

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  // Lockstep pipeline advance; every stage holds while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {DATA_WIDTH{1'b0}};
      s2_valid_r <= 1'b0;
      s2_data_r  <= {DATA_WIDTH{1'b0}};
      s2_k_r     <= {INT_WIDTH{1'b0}};
      s2_zero_r  <= 1'b0;
      out_valid  <= 1'b0;
      log_out    <= {(INT_WIDTH+FRAC_WIDTH){1'b0}};
      zero_flag  <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= in_data;
      end else begin
        s1_data_r <= s1_data_r;
      end
      s2_valid_r <= s1_valid_r;
      s2_data_r  <= s1_data_r;
      s2_k_r     <= msb_index(s1_data_r);
      s2_zero_r  <= (s1_data_r == {DATA_WIDTH{1'b0}});
      out_valid  <= s2_valid_r;
      log_out    <= {s2_k_r, calc_frac(s2_data_r, s2_k_r)};
      zero_flag  <= s2_zero_r;
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_data_r  <= s1_data_r;
      s2_valid_r <= s2_valid_r;
      s2_data_r  <= s2_data_r;
      s2_k_r     <= s2_k_r;
      s2_zero_r  <= s2_zero_r;
      out_valid  <= out_valid;
      log_out    <= log_out;
      zero_flag  <= zero_flag;
    end
  end

endmodule

// File: tb/tb_mitchell_log2_pipe.sv
// Self-checking bench for mitchell_log2_pipe at default parameters (16-bit in, Q4.8 out).
module tb_mitchell_log2_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] log_out;
  logic        zero_flag;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;
  logic [12:0] exp_q[$];

  mitchell_log2_pipe dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .log_out(log_out), .zero_flag(zero_flag), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {zero, k, frac} with k found by scanning down from the top bit.
  function automatic logic [12:0] ref_log(input logic [15:0] x);
    int k;
    int m;
    int frac;
    if (x == 16'h0000) return {1'b1, 12'h000};
    k = 15;
    while (x[k] == 1'b0) k--;
    m = int'(x) - (1 << k);
    if (k >= 8) frac = m >> (k - 8);
    else frac = m << (8 - k);
    return {1'b0, 4'(k), 8'(frac)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || log_out !== 12'h000 || zero_flag !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_init: got valid=%b log=%h zero=%b rdy=%b, want 0/000/0/1", out_valid, log_out, zero_flag, in_ready);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h0A3F + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill: out_valid got %b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || log_out !== 12'h000 || zero_flag !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got valid=%b log=%h zero=%b, want 0/000/0", out_valid, log_out, zero_flag);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_stale: cycle %0d out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_single(input logic [15:0] x, input logic [11:0] exp_log,
                             input logic exp_zero, input string name);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = x;
    tick();
    in_valid = 1'b0; in_data = 16'hDEAD;
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL %s_latency: got %0d want 3", name, n);
    end
    checks++;
    if (log_out !== exp_log || zero_flag !== exp_zero) begin
      failures++;
      $display("FAIL %s_value: got log=%h zero=%b want log=%h zero=%b", name, log_out, zero_flag, exp_log, exp_zero);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drop: out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_single_samples();
    test_single(16'h0A3F, 12'hB47, 1'b0, "s_0a3f");
    test_single(16'h0005, 12'h240, 1'b0, "s_0005");
    test_single(16'hFFFF, 12'hFFF, 1'b0, "s_ffff");
  endtask

  task automatic test_boundaries();
    test_single(16'h0000, 12'h000, 1'b1, "b_zero");
    test_single(16'h0001, 12'h000, 1'b0, "b_one");
    test_single(16'h0100, 12'h800, 1'b0, "b_0100");
    test_single(16'h0080, 12'h700, 1'b0, "b_0080");
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    int got;
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 1003; i++) begin
      if (i < 1000) begin
        in_valid = 1'b1; in_data = 16'($urandom);
        exp_q.push_back(ref_log(in_data));
      end else begin
        in_valid = 1'b0;
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== (i >= 3)) begin
        failures++;
        $display("FAIL b2b_flow: step %0d rdy=%b valid=%b want rdy=1 valid=%b", i, in_ready, out_valid, (i >= 3));
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if ({zero_flag, log_out} !== e) begin
          failures++;
          $display("FAIL b2b_data: out %0d got %h want %h", got, {zero_flag, log_out}, e);
        end
      end
      tick();
    end
    checks++;
    if (got !== 1000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count: got %0d outputs valid=%b want 1000 outputs valid=0", got, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0A3F; tick();
    in_data = 16'h0005; tick();
    in_data = 16'hFFFF; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || log_out !== 12'hB47 || zero_flag !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d rdy=%b valid=%b log=%h want 0/1/b47", i, in_ready, out_valid, log_out);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || log_out !== 12'hB47) begin
      failures++;
      $display("FAIL bp_first: rdy=%b log=%h want 1/b47", in_ready, log_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || log_out !== 12'h240) begin
      failures++;
      $display("FAIL bp_second: valid=%b log=%h want 1/240", out_valid, log_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || log_out !== 12'hFFF) begin
      failures++;
      $display("FAIL bp_third: valid=%b log=%h want 1/fff", out_valid, log_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    logic        prev_stall;
    logic [12:0] prev_out;
    int accepted;
    int cyc;
    prev_stall = 1'b0;
    prev_out = 13'h0000;
    accepted = 0;
    cyc = 0;
    while ((accepted < 5000 || exp_q.size() > 0) && cyc < 40000) begin
      in_valid  = (accepted < 5000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 16'($urandom);
      out_ready = (accepted < 5000) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {zero_flag, log_out} !== prev_out) begin
          failures++;
          $display("FAIL rnd_stable: cycle %0d valid=%b out=%h want 1/%h", cyc, out_valid, {zero_flag, log_out}, prev_out);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra: cycle %0d unexpected output %h", cyc, {zero_flag, log_out});
        end else begin
          e = exp_q.pop_front();
          if ({zero_flag, log_out} !== e) begin
            failures++;
            $display("FAIL rnd_data: cycle %0d got %h want %h", cyc, {zero_flag, log_out}, e);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(ref_log(in_data));
        accepted++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_out = {zero_flag, log_out};
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (accepted !== 5000 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL rnd_complete: accepted %0d pending %0d want 5000/0", accepted, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_samples();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
